// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// FSM state encodings and the byte-packing geometry.
package instr_mem_loader_pkg;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        CHK   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam int HDR_BYTES  = 4;
    localparam int BYTE_CNT_W = $clog2(HDR_BYTES);

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Big-endian 8->32 packer: collects bytes MSB first and flags the cycle the
// fourth byte of a word is accepted, presenting the full word combinationally.
module instr_mem_loader_byte_packer
    import instr_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [23:0]           shift;

    // The word is complete on the same edge its last byte arrives, so the FSM
    // can act without an extra cycle of latency.
    assign word       = {shift, byte_data};
    assign word_valid = take && (byte_cnt == BYTE_CNT_W'(HDR_BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            shift    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            shift    <= '0;
        end else if (take) begin
            byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            shift    <= {shift[15:0], byte_data};
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: receives count, N words and an XOR checksum over a byte link,
// writes the words into instruction memory and releases the CPU on success.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int                MEM_DEPTH = 256,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    input  logic              load_req_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int IDX_W = $clog2(MEM_DEPTH) + 1;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       count;
    logic [31:0]       acc;
    logic [31:0]       word;
    logic              word_valid;
    logic              take;
    logic              reload;

    // The WRITE cycle deliberately drops ready so the stream stalls one cycle per word.
    assign byte_ready_o = ~rst_i & ((state == HDR) | (state == LOAD) | (state == CHK));
    assign take         = byte_valid_i & byte_ready_o;
    assign reload       = load_req_i & ((state == DONE) | (state == ERR));

    instr_mem_loader_byte_packer u_packer (
        .clk        (clk_i),
        .rst        (rst_i),
        .clear      (reload),
        .take       (take),
        .byte_data  (byte_data_i),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= HDR;
            idx       <= '0;
            count     <= '0;
            acc       <= '0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            cpu_rst_o <= 1'b1;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            wr_en_o <= 1'b0;
            unique case (state)
                HDR: begin
                    if (word_valid) begin
                        count <= word;
                        if (word > 32'(MEM_DEPTH)) begin
                            state <= ERR;
                            err_o <= 1'b1;
                        end else if (word == '0) begin
                            state <= CHK;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (word_valid) begin
                        state     <= WRITE;
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= BASE_ADDR + (ADDR_W'(idx) << 2);
                        wr_data_o <= word;
                    end
                end
                WRITE: begin
                    acc <= acc ^ wr_data_o;
                    if (32'(idx) == count - 32'd1) begin
                        state <= CHK;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= LOAD;
                    end
                end
                CHK: begin
                    if (word_valid) begin
                        if (word == acc) begin
                            state     <= DONE;
                            done_o    <= 1'b1;
                            cpu_rst_o <= 1'b0;
                        end else begin
                            state <= ERR;
                            err_o <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    // A reload puts the CPU back in reset before any new word lands.
                    if (load_req_i) begin
                        state     <= HDR;
                        idx       <= '0;
                        count     <= '0;
                        acc       <= '0;
                        done_o    <= 1'b0;
                        err_o     <= 1'b0;
                        cpu_rst_o <= 1'b1;
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed scenarios plus randomized
// images compared against a list-of-writes / XOR reference model.
module tb_instr_mem_loader;

    localparam int          MEM_DEPTH = 256;
    localparam int          ADDR_W    = 32;
    localparam logic [31:0] BASE      = 32'h0;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        load_req_i;
    logic        wr_en_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic        cpu_rst_o;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int ready_in_write = 0;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [31:0] img[$];

    instr_mem_loader #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .load_req_i   (load_req_i),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .cpu_rst_o    (cpu_rst_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Record every memory write, and note any cycle where a write coincides with ready.
    always @(negedge clk_i) begin
        if (!rst_i && wr_en_o) begin
            obs_addr.push_back(wr_addr_o);
            obs_data.push_back(wr_data_o);
            if (byte_ready_o) ready_in_write++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        int waited;
        if (gaps) begin
            n = $urandom_range(0, 3);
            repeat (n) begin
                @(negedge clk_i);
                byte_valid_i = 1'b0;
            end
        end
        @(negedge clk_i);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        waited = 0;
        while (!byte_ready_o && waited < 50) begin
            @(negedge clk_i);
            waited++;
        end
        checks++;
        if (!byte_ready_o) begin
            errors++;
            $display("[TB] FAIL byte_accept timeout: byte_ready_o=%0b required 1", byte_ready_o);
        end else begin
            @(posedge clk_i);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gaps);
    endtask

    // Header, then (if the count fits) every word of img and the checksum.
    task automatic send_image(input logic [31:0] cnt, input logic [31:0] chk, input bit gaps);
        send_word(cnt, gaps);
        if (cnt <= 32'(MEM_DEPTH)) begin
            foreach (img[k]) send_word(img[k], gaps);
            send_word(chk, gaps);
        end
        @(negedge clk_i);
        byte_valid_i = 1'b0;
    endtask

    task automatic wait_result();
        int c;
        c = 0;
        while (!(done_o || err_o) && c < 40) begin
            @(negedge clk_i);
            c++;
        end
    endtask

    task automatic restart();
        if (done_o || err_o) begin
            @(negedge clk_i);
            load_req_i = 1'b1;
            @(negedge clk_i);
            load_req_i = 1'b0;
        end
        obs_addr.delete();
        obs_data.delete();
        ready_in_write = 0;
    endtask

    function automatic logic [31:0] image_xor();
        logic [31:0] x;
        x = '0;
        foreach (img[k]) x ^= img[k];
        return x;
    endfunction

    function automatic void load_scenario1();
        img.delete();
        img.push_back(32'h20080005);
        img.push_back(32'h2009000A);
    endfunction

    task automatic test_reset();
        rst_i = 1'b1;
        byte_valid_i = 1'b0;
        byte_data_i = 8'h00;
        load_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({byte_ready_o, wr_en_o, cpu_rst_o, done_o, err_o} !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL reset_flags: got rdy/wen/cpurst/done/err=%b required 00100",
                     {byte_ready_o, wr_en_o, cpu_rst_o, done_o, err_o});
        end
        checks++;
        if ({wr_addr_o, wr_data_o} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus: addr=%h data=%h required 0/0", wr_addr_o, wr_data_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (byte_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_reset: got %b required 1", byte_ready_o);
        end
    endtask

    task automatic test_basic();
        restart();
        load_scenario1();
        send_image(32'd2, 32'h0001000F, 1'b0);
        wait_result();
        checks++;
        if (obs_addr.size() !== 2) begin
            errors++;
            $display("[TB] FAIL basic_write_count: got %0d required 2", obs_addr.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_addr[k] !== BASE + 32'(4*k) || obs_data[k] !== img[k]) begin
                    errors++;
                    $display("[TB] FAIL basic_write%0d: got (%h,%h) required (%h,%h)", k,
                             obs_addr[k], obs_data[k], BASE + 32'(4*k), img[k]);
                end
            end
        end
        checks++;
        if ({done_o, err_o, cpu_rst_o} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL basic_status: done/err/cpurst=%b required 100", {done_o, err_o, cpu_rst_o});
        end
    endtask

    task automatic test_latency();
        logic [31:0] w;
        restart();
        w = $urandom;
        img.delete();
        img.push_back(w);
        send_word(32'd1, 1'b0);
        send_word(w, 1'b0);
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        checks++;
        if ({wr_en_o, byte_ready_o} !== 2'b10 || wr_addr_o !== BASE || wr_data_o !== w) begin
            errors++;
            $display("[TB] FAIL latency_write: wen/rdy=%b addr=%h data=%h required 10 %h %h",
                     {wr_en_o, byte_ready_o}, wr_addr_o, wr_data_o, BASE, w);
        end
        @(negedge clk_i);
        checks++;
        if ({wr_en_o, byte_ready_o} !== 2'b01 || wr_data_o !== w) begin
            errors++;
            $display("[TB] FAIL latency_after: wen/rdy=%b data=%h required 01 %h",
                     {wr_en_o, byte_ready_o}, wr_data_o, w);
        end
        send_word(w, 1'b0);
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        wait_result();
        checks++;
        if ({done_o, err_o, cpu_rst_o} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL latency_status: done/err/cpurst=%b required 100", {done_o, err_o, cpu_rst_o});
        end
    endtask

    task automatic test_zero_count();
        restart();
        img.delete();
        send_image(32'd0, 32'h0, 1'b0);
        wait_result();
        checks++;
        if (obs_addr.size() !== 0 || {done_o, err_o, cpu_rst_o} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL zero_ok: writes=%0d done/err/cpurst=%b required 0 100",
                     obs_addr.size(), {done_o, err_o, cpu_rst_o});
        end
        restart();
        send_image(32'd0, 32'h1, 1'b0);
        wait_result();
        checks++;
        if (obs_addr.size() !== 0 || {done_o, err_o, cpu_rst_o} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL zero_badchk: writes=%0d done/err/cpurst=%b required 0 011",
                     obs_addr.size(), {done_o, err_o, cpu_rst_o});
        end
    endtask

    task automatic test_oversize();
        logic [31:0] big [2];
        logic [31:0] x;
        big[0] = 32'(MEM_DEPTH + 1);
        big[1] = 32'h80000100;
        for (int t = 0; t < 2; t++) begin
            restart();
            img.delete();
            send_image(big[t], 32'h0, 1'b0);
            checks++;
            if (obs_addr.size() !== 0 || {err_o, done_o, byte_ready_o, cpu_rst_o} !== 4'b1001) begin
                errors++;
                $display("[TB] FAIL oversize_%h: writes=%0d err/done/rdy/cpurst=%b required 0 1001",
                         big[t], obs_addr.size(), {err_o, done_o, byte_ready_o, cpu_rst_o});
            end
        end
        // Exactly full memory is legal.
        restart();
        img.delete();
        for (int k = 0; k < MEM_DEPTH; k++) img.push_back($urandom);
        x = image_xor();
        send_image(32'(MEM_DEPTH), x, 1'b0);
        wait_result();
        checks++;
        if (obs_addr.size() !== MEM_DEPTH || {done_o, err_o} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL full_depth: writes=%0d done/err=%b required %0d 10",
                     obs_addr.size(), {done_o, err_o}, MEM_DEPTH);
        end else begin
            checks++;
            if (obs_addr[MEM_DEPTH-1] !== BASE + 32'(4*(MEM_DEPTH-1)) || obs_data[MEM_DEPTH-1] !== img[MEM_DEPTH-1]) begin
                errors++;
                $display("[TB] FAIL full_depth_last: got (%h,%h) required (%h,%h)",
                         obs_addr[MEM_DEPTH-1], obs_data[MEM_DEPTH-1],
                         BASE + 32'(4*(MEM_DEPTH-1)), img[MEM_DEPTH-1]);
            end
        end
    endtask

    task automatic test_bad_checksum();
        restart();
        load_scenario1();
        send_image(32'd2, 32'h0001000E, 1'b0);
        wait_result();
        checks++;
        if (obs_addr.size() !== 2 || {done_o, err_o, cpu_rst_o} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL bad_checksum: writes=%0d done/err/cpurst=%b required 2 011",
                     obs_addr.size(), {done_o, err_o, cpu_rst_o});
        end
    endtask

    task automatic test_back_to_back();
        for (int g = 0; g < 2; g++) begin
            restart();
            load_scenario1();
            send_image(32'd2, 32'h0001000F, g[0]);
            wait_result();
            checks++;
            if (ready_in_write !== 0) begin
                errors++;
                $display("[TB] FAIL b2b_ready_in_write(g=%0d): got %0d required 0", g, ready_in_write);
            end
            checks++;
            if (obs_addr.size() !== 2 || obs_data[0] !== 32'h20080005 || obs_data[1] !== 32'h2009000A ||
                obs_addr[1] !== BASE + 32'd4 || done_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_writes(g=%0d): writes=%0d done=%b required 2 writes done=1",
                         g, obs_addr.size(), done_o);
            end
        end
    endtask

    task automatic test_load_req_ignored();
        logic [31:0] w;
        restart();
        w = $urandom;
        load_req_i = 1'b1;
        send_word(32'd1, 1'b0);
        send_word(w, 1'b0);
        load_req_i = 1'b0;
        send_word(w, 1'b0);
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        wait_result();
        checks++;
        if (obs_addr.size() !== 1 || {done_o, err_o} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL load_req_ignored: writes=%0d done/err=%b required 1 10",
                     obs_addr.size(), {done_o, err_o});
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] x;
        restart();
        load_scenario1();
        send_word(32'd2, 1'b0);
        send_word(img[0], 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        byte_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({byte_ready_o, wr_en_o, cpu_rst_o, done_o, err_o} !== 5'b00100 || {wr_addr_o, wr_data_o} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL midload_reset: flags=%b addr=%h data=%h required 00100 0 0",
                     {byte_ready_o, wr_en_o, cpu_rst_o, done_o, err_o}, wr_addr_o, wr_data_o);
        end
        rst_i = 1'b0;
        restart();
        send_image(32'd2, 32'h0001000F, 1'b0);
        wait_result();
        checks++;
        if (obs_addr.size() !== 2 || {done_o, cpu_rst_o} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL midload_recover: writes=%0d done/cpurst=%b required 2 10",
                     obs_addr.size(), {done_o, cpu_rst_o});
        end
        @(negedge clk_i);
        load_req_i = 1'b1;
        @(negedge clk_i);
        load_req_i = 1'b0;
        checks++;
        if ({cpu_rst_o, done_o, err_o, byte_ready_o} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL reload_edge: cpurst/done/err/rdy=%b required 1001",
                     {cpu_rst_o, done_o, err_o, byte_ready_o});
        end
        restart();
        img.delete();
        for (int k = 0; k < 3; k++) img.push_back($urandom);
        x = image_xor();
        send_image(32'd3, x, 1'b1);
        wait_result();
        checks++;
        if (obs_addr.size() !== 3 || obs_data[2] !== img[2] || done_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reload_image: writes=%0d done=%b required 3 1", obs_addr.size(), done_o);
        end
    endtask

    task automatic test_random_images();
        int n;
        bit bad;
        logic [31:0] x;
        logic [31:0] chk;
        for (int it = 0; it < 8; it++) begin
            restart();
            n = $urandom_range(1, 8);
            img.delete();
            for (int k = 0; k < n; k++) img.push_back($urandom);
            x = image_xor();
            bad = ($urandom_range(0, 3) == 0);
            chk = bad ? (x ^ (32'd1 << $urandom_range(0, 31))) : x;
            send_image(32'(n), chk, 1'b1);
            wait_result();
            checks++;
            if (obs_addr.size() !== n) begin
                errors++;
                $display("[TB] FAIL rand%0d_count: got %0d required %0d", it, obs_addr.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    checks++;
                    if (obs_addr[k] !== BASE + 32'(4*k) || obs_data[k] !== img[k]) begin
                        errors++;
                        $display("[TB] FAIL rand%0d_write%0d: got (%h,%h) required (%h,%h)", it, k,
                                 obs_addr[k], obs_data[k], BASE + 32'(4*k), img[k]);
                    end
                end
            end
            checks++;
            if ({done_o, err_o, cpu_rst_o} !== (bad ? 3'b011 : 3'b100)) begin
                errors++;
                $display("[TB] FAIL rand%0d_status: done/err/cpurst=%b required %b", it,
                         {done_o, err_o, cpu_rst_o}, bad ? 3'b011 : 3'b100);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_zero_count();
        test_oversize();
        test_bad_checksum();
        test_back_to_back();
        test_load_req_ignored();
        test_reset_mid_load();
        test_random_images();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
